// File: rtl/voice_sched_pkg.sv
// Shared constants and processing-FSM encoding for the voice frame scheduler.
package voice_sched_pkg;

   localparam int unsigned VS_DATA_W      = 16;
   localparam int unsigned VS_FRAME_LEN   = 256;
   localparam int unsigned VS_ADDR_W      = $clog2(VS_FRAME_LEN);
   localparam int unsigned VS_TIMEOUT_CYC = 65535;

   typedef enum logic [1:0] {
      P_IDLE  = 2'd0,
      P_START = 2'd1,
      P_WAIT  = 2'd2
   } proc_state_t;

endpackage

// File: rtl/sck_edge_sync.sv
// Two-flop synchroniser for a slow audio clock plus a registered rising-edge pulse.
module sck_edge_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sck,
   output logic o_rise
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_rise;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_meta <= i_sck;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_rise <= r_sync & ~r_prev;
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/voice_frame_sched.sv
// Ping-pong frame capture and engine handshake for voice_change.
// Optional watchdog on the engine job: define VOICE_SCHED_TIMEOUT_EN.
module voice_frame_sched
   import voice_sched_pkg::*;
#(
   parameter int unsigned DATA_W    = VS_DATA_W,
   parameter int unsigned FRAME_LEN = VS_FRAME_LEN,
   parameter int unsigned ADDR_W    = VS_ADDR_W
`ifdef VOICE_SCHED_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = VS_TIMEOUT_CYC
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sck,
   input  logic [DATA_W-1:0] ldata_in,
   output logic              buf_wr_en,
   output logic [ADDR_W:0]   buf_wr_addr,
   output logic [DATA_W-1:0] buf_wr_data,
   output logic              proc_start,
   output logic              proc_bank,
   input  logic              proc_done,
   output logic              busy,
   output logic [15:0]       frame_cnt,
   output logic              overrun,
   input  logic              overrun_clr
`ifdef VOICE_SCHED_TIMEOUT_EN
   ,
   output logic              proc_timeout,
   output logic              proc_abort
`endif
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

   logic              w_rise;
   logic              w_frame_end;
   logic              w_accept;
   logic              w_drop;
   logic              w_timeout;
   proc_state_t       r_state;
   proc_state_t       w_state_nxt;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic              r_wr_bank;
   logic              r_wr_en;
   logic [ADDR_W:0]   r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_proc_start;
   logic              r_proc_bank;
   logic              r_busy;
   logic [15:0]       r_frame_cnt;
   logic              r_overrun;
`ifdef VOICE_SCHED_TIMEOUT_EN
   logic [15:0]       r_to_cnt;
   logic              r_timeout;
   logic              r_abort;
`endif

   sck_edge_sync u_sck_sync (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_sck  (sck),
      .o_rise (w_rise)
   );

   // Last word of a frame is being written this cycle.
   assign w_frame_end = r_wr_en && (r_wr_addr[ADDR_W-1:0] == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_wr_ptr  <= '0;
         r_wr_bank <= 1'b0;
      end else begin
         r_wr_en <= w_rise;
         if (w_rise) begin
            r_wr_addr <= {r_wr_bank, r_wr_ptr};
            r_wr_data <= ldata_in;
            r_wr_ptr  <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_accept) begin
            r_wr_bank <= ~r_wr_bank;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= P_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A dropped frame leaves wr_bank alone so the next frame overwrites it.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         P_IDLE: begin
            if (w_frame_end) begin
               w_accept    = 1'b1;
               w_state_nxt = P_START;
            end
         end
         P_START: w_state_nxt = P_WAIT;
         P_WAIT: begin
            if (proc_done) begin
               if (w_frame_end) begin
                  w_accept    = 1'b1;
                  w_state_nxt = P_START;
               end else begin
                  w_state_nxt = P_IDLE;
               end
`ifdef VOICE_SCHED_TIMEOUT_EN
            end else if (r_to_cnt == 16'(TIMEOUT_CYC - 1)) begin
               w_timeout   = 1'b1;
               w_state_nxt = P_IDLE;
`endif
            end
         end
         default: w_state_nxt = P_IDLE;
      endcase
      w_drop = w_frame_end && !w_accept;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_proc_start <= 1'b0;
         r_proc_bank  <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_cnt  <= '0;
         r_overrun    <= 1'b0;
      end else begin
         r_proc_start <= w_accept;
         r_busy       <= (w_state_nxt != P_IDLE);
         if (w_accept) begin
            r_proc_bank <= r_wr_addr[ADDR_W];
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (overrun_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

`ifdef VOICE_SCHED_TIMEOUT_EN
   // Watchdog counts consecutive P_WAIT cycles; banks stay as they are on abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
         r_abort   <= 1'b0;
      end else begin
         r_to_cnt <= (r_state == P_WAIT && w_state_nxt == P_WAIT) ? r_to_cnt + 16'd1 : 16'd0;
         r_abort  <= w_timeout;
         if (w_timeout) begin
            r_timeout <= 1'b1;
         end else if (overrun_clr) begin
            r_timeout <= 1'b0;
         end
      end
   end

   assign proc_timeout = r_timeout;
   assign proc_abort   = r_abort;
`endif

   assign buf_wr_en   = r_wr_en;
   assign buf_wr_addr = r_wr_addr;
   assign buf_wr_data = r_wr_data;
   assign proc_start  = r_proc_start;
   assign proc_bank   = r_proc_bank;
   assign busy        = r_busy;
   assign frame_cnt   = r_frame_cnt;
   assign overrun     = r_overrun;

endmodule

// File: tb/tb_voice_frame_sched.sv
// Scoreboard bench for voice_frame_sched: random data and engine latency against a frame-level model.
module tb_voice_frame_sched;

   localparam int unsigned DW = 16;
   localparam int unsigned FL = 8;
   localparam int unsigned AW = 3;
   localparam int unsigned TO = 100;
   // sck rises 7 time units before a clk rise; write is seen mid-cycle 3 clk later.
   localparam logic [63:0] WR_LAT = 64'd77;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sck = 1'b0;
   logic          proc_done = 1'b0;
   logic          overrun_clr = 1'b0;
   logic [DW-1:0] ldata_in = '0;
   logic          buf_wr_en;
   logic [AW:0]   buf_wr_addr;
   logic [DW-1:0] buf_wr_data;
   logic          proc_start;
   logic          proc_bank;
   logic          busy;
   logic [15:0]   frame_cnt;
   logic          overrun;
`ifdef VOICE_SCHED_TIMEOUT_EN
   logic          proc_timeout;
   logic          proc_abort;
`endif

   voice_frame_sched #(
      .DATA_W    (DW),
      .FRAME_LEN (FL),
      .ADDR_W    (AW)
`ifdef VOICE_SCHED_TIMEOUT_EN
      ,
      .TIMEOUT_CYC (TO)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sck         (sck),
      .ldata_in    (ldata_in),
      .buf_wr_en   (buf_wr_en),
      .buf_wr_addr (buf_wr_addr),
      .buf_wr_data (buf_wr_data),
      .proc_start  (proc_start),
      .proc_bank   (proc_bank),
      .proc_done   (proc_done),
      .busy        (busy),
      .frame_cnt   (frame_cnt),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
`ifdef VOICE_SCHED_TIMEOUT_EN
      ,
      .proc_timeout (proc_timeout),
      .proc_abort   (proc_abort)
`endif
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [AW:0]   addr;
      logic [DW-1:0] data;
      longint        t_rise;
   } wr_exp_t;

   typedef struct {
      logic        bank;
      logic [15:0] cnt;
   } st_exp_t;

   wr_exp_t wr_q[$];
   st_exp_t st_q[$];
   int      n_checks = 0;
   int      n_pass   = 0;

   // Frame-level reference model
   int      m_ptr = 0;
   bit      m_bank = 1'b0;
   int      m_cnt = 0;
   bit      m_overrun = 1'b0;

   // Engine responder state
   bit      eng_busy = 1'b0;
   bit      eng_hold = 1'b0;
   bit      eng_rand = 1'b0;
   bit      release_now = 1'b0;
   int      eng_delay = 50;

   longint  cyc = 0;
   longint  last_start_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic align();
      @(negedge clk);
      #3;
   endtask

   task automatic model_reset();
      m_ptr     = 0;
      m_bank    = 1'b0;
      m_cnt     = 0;
      m_overrun = 1'b0;
      wr_q.delete();
      st_q.delete();
   endtask

   // One sck period; the frame-end decision is made in the cycle the last word is written.
   task automatic send_sample(input logic [DW-1:0] d, input bit rel_at_end, input bit clr_at_end);
      longint  t0;
      bit      last;
      wr_exp_t e;
      st_exp_t s;
      ldata_in = d;
      #500;
      sck = 1'b1;
      t0 = $time;
      last = (m_ptr == int'(FL) - 1);
      e.addr = {m_bank, AW'(m_ptr)};
      e.data = d;
      e.t_rise = t0;
      wr_q.push_back(e);
      m_ptr = (m_ptr + 1) % int'(FL);
      repeat (3) @(posedge clk);
      #1;
      if (last && rel_at_end) release_now = 1'b1;
      if (last && clr_at_end) overrun_clr = 1'b1;
      @(posedge clk);
      #10;
      if (last) begin
         if (!eng_busy) begin
            m_cnt = (m_cnt + 1) % 65536;
            s.bank = m_bank;
            s.cnt = 16'(m_cnt);
            st_q.push_back(s);
            m_bank = !m_bank;
         end else begin
            m_overrun = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      overrun_clr = 1'b0;
      #(t0 + 1000 - longint'($time));
      sck = 1'b0;
      #500;
   endtask

   task automatic send_frame(input bit rnd, input int base, input bit rel, input bit clr);
      align();
      for (int i = 0; i < int'(FL); i++) begin
         send_sample(rnd ? 16'($urandom) : 16'(base + i), rel, clr);
      end
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      m_overrun = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_wr_en"}, 64'(buf_wr_en), 64'd0);
      check({tag, "_wr_addr"}, 64'(buf_wr_addr), 64'd0);
      check({tag, "_wr_data"}, 64'(buf_wr_data), 64'd0);
      check({tag, "_proc_start"}, 64'(proc_start), 64'd0);
      check({tag, "_proc_bank"}, 64'(proc_bank), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
      check({tag, "_overrun"}, 64'(overrun), 64'd0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT writes or starts the engine.
   always @(negedge clk) begin : monitor
      wr_exp_t e;
      st_exp_t s;
      if (!rst) begin
         if (buf_wr_en) begin
            if (wr_q.size() == 0) begin
               check("unexpected_write", 64'd1, 64'd0);
            end else begin
               e = wr_q.pop_front();
               check("wr_addr", 64'(buf_wr_addr), 64'(e.addr));
               check("wr_data", 64'(buf_wr_data), 64'(e.data));
               check("wr_latency", 64'($time) - 64'(e.t_rise), WR_LAT);
            end
         end
         if (proc_start) begin
            last_start_cyc = cyc;
            if (st_q.size() == 0) begin
               check("unexpected_start", 64'd1, 64'd0);
            end else begin
               s = st_q.pop_front();
               check("start_proc_bank", 64'(proc_bank), 64'(s.bank));
               check("start_frame_cnt", 64'(frame_cnt), 64'(s.cnt));
               check("start_busy", 64'(busy), 64'd1);
            end
         end
      end
   end

   // Engine model: reacts to proc_start with a fixed, random or held latency.
   initial begin : engine
      forever begin
         @(negedge clk);
         if (proc_start && !rst) begin
            eng_busy = 1'b1;
            if (eng_hold) begin
               do @(posedge clk); while (eng_hold && !release_now);
               release_now = 1'b0;
            end else begin
               repeat (eng_rand ? int'($urandom_range(1200, 3)) : eng_delay) @(posedge clk);
            end
            #1;
            proc_done = 1'b1;
            eng_busy = 1'b0;
            @(posedge clk);
            #1;
            proc_done = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int k;
      #100;
      check_outputs_zero("reset");
      #1900;
      rst = 1'b0;

      // Two ramp frames with a quick engine
      eng_delay = 50;
      send_frame(1'b0, 0, 1'b0, 1'b0);
      send_frame(1'b0, 8, 1'b0, 1'b0);
      check("a_busy", 64'(busy), 64'd0);
      check("a_frame_cnt", 64'(frame_cnt), 64'd2);
      check("a_proc_bank", 64'(proc_bank), 64'd1);
      check("a_overrun", 64'(overrun), 64'd0);

      // Engine stalls: one accept, then two drops into bank 1 (clear lost to set on the last)
      eng_hold = 1'b1;
      send_frame(1'b0, 16, 1'b0, 1'b0);
      send_frame(1'b0, 24, 1'b0, 1'b0);
      send_frame(1'b0, 32, 1'b0, 1'b1);
      check("b_overrun", 64'(overrun), 64'(m_overrun));
      check("b_overrun_set", 64'(overrun), 64'd1);
      check("b_frame_cnt", 64'(frame_cnt), 64'd3);
      check("b_busy", 64'(busy), 64'd1);
      check("b_proc_bank", 64'(proc_bank), 64'd0);
      pulse_clr();
      check("b_overrun_clr", 64'(overrun), 64'd0);

      // proc_done lands in the cycle of the final write
      send_frame(1'b0, 40, 1'b1, 1'b0);
      check("c_overrun", 64'(overrun), 64'd0);
      check("c_proc_bank", 64'(proc_bank), 64'd1);
      check("c_frame_cnt", 64'(frame_cnt), 64'd4);
      check("c_busy", 64'(busy), 64'd1);

      // Reset mid-frame with an engine job outstanding
      align();
      for (int i = 0; i < 5; i++) send_sample(16'($urandom), 1'b0, 1'b0);
      @(negedge clk);
      #5;
      rst = 1'b1;
      #1;
      check_outputs_zero("async_rst");
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      eng_hold = 1'b0;
      repeat (10) @(negedge clk);
      check("d_busy", 64'(busy), 64'd0);
      check("d_frame_cnt", 64'(frame_cnt), 64'd0);
      send_frame(1'b0, 100, 1'b0, 1'b0);
      check("d_frame_cnt_after", 64'(frame_cnt), 64'd1);

      // Random data and random engine latency
      eng_rand = 1'b1;
      for (int f = 0; f < 6; f++) begin
         send_frame(1'b1, 0, 1'b0, 1'b0);
         check("e_overrun", 64'(overrun), 64'(m_overrun));
         check("e_frame_cnt", 64'(frame_cnt), 64'(m_cnt));
         if (m_overrun) pulse_clr();
      end

      k = 0;
      while (eng_busy && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("engine_idle", 64'(eng_busy), 64'd0);
      repeat (20) @(negedge clk);

`ifdef VOICE_SCHED_TIMEOUT_EN
      // Watchdog: no proc_done after an accepted frame
      eng_rand = 1'b0;
      eng_hold = 1'b1;
      send_frame(1'b1, 0, 1'b0, 1'b0);
      k = 0;
      while (!proc_abort && k < 400) begin
         @(negedge clk);
         k++;
      end
      check("to_abort_seen", 64'(proc_abort), 64'd1);
      check("to_abort_cycle", 64'(cyc - last_start_cyc), 64'(TO + 1));
      check("to_busy", 64'(busy), 64'd0);
      check("to_timeout", 64'(proc_timeout), 64'd1);
      @(negedge clk);
      check("to_abort_pulse", 64'(proc_abort), 64'd0);
      pulse_clr();
      check("to_timeout_clr", 64'(proc_timeout), 64'd0);
      eng_hold = 1'b0;
      repeat (10) @(negedge clk);
      st_q.delete();
`endif

      repeat (200) @(negedge clk);
      check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
      check("start_queue_drained", 64'(st_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
